// File: rtl/rnn_matvec_mac.sv
// rnn_matvec_mac
//   Sequential matrix-vector MAC engine: y = W*x using one signed multiplier.
//   Fetches one W/x element pair per cycle from rnn storage, accumulates a
//   row at full precision, then emits the scaled and saturated row result.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start          begin a computation (sampled only when idle)
//   busy, done     run in progress / one-cycle completion pulse
//   w_row, w_col   weight element address; w_data returns it combinationally
//   x_idx          input vector element address (== w_col); x_data returns it
//   y_valid        one-cycle strobe qualifying y_idx / y_data
//   y_idx, y_data  output row index and saturated fixed-point result
`timescale 1ns/1ps
module rnn_matvec_mac #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] w_row,
    output logic [AW-1:0] w_col,
    input  logic [DW-1:0] w_data,
    output logic [AW-1:0] x_idx,
    input  logic [DW-1:0] x_data,
    output logic          y_valid,
    output logic [AW-1:0] y_idx,
    output logic [DW-1:0] y_data
);

    // Headroom of clog2(COLS)+1 bits above the full product keeps a whole
    // row sum exact.
    localparam int ACW = 2*DW + $clog2(COLS) + 1;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS-1);
    localparam logic [AW-1:0] LAST_COL = AW'(COLS-1);

    localparam logic signed [ACW-1:0] SAT_MAX = {{(ACW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACW-1:0] SAT_MIN = {{(ACW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

    state_t                 state, state_nxt;
    logic [AW-1:0]          row, col;
    logic signed [ACW-1:0]  acc;
    logic signed [2*DW-1:0] prod;
    logic signed [ACW-1:0]  scaled;
    logic [DW-1:0]          sat_val;

    assign prod = $signed(w_data) * $signed(x_data);

    // Arithmetic shift: truncation toward negative infinity, no rounding.
    assign scaled = acc >>> FRAC;

    always_comb begin
        sat_val = scaled[DW-1:0];
        if (scaled > SAT_MAX)
            sat_val = SAT_MAX[DW-1:0];
        else if (scaled < SAT_MIN)
            sat_val = SAT_MIN[DW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = MAC;
            MAC:  if (col == LAST_COL) state_nxt = EMIT;
            EMIT: state_nxt = (row == LAST_ROW) ? DONE : MAC;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    acc <= '0;
                end
                MAC: begin
                    acc <= acc + ACW'(prod);
                    if (col != LAST_COL)
                        col <= col + AW'(1);
                end
                EMIT: begin
                    acc <= '0;
                    col <= '0;
                    if (row != LAST_ROW)
                        row <= row + AW'(1);
                end
                DONE: begin
                    // Counters return to zero so addresses read 0 while idle.
                    row <= '0;
                    col <= '0;
                end
                default: begin
                    row <= '0;
                    col <= '0;
                    acc <= '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from registered state and counters.
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign y_valid = (state == EMIT);
    assign y_idx   = y_valid ? row : '0;
    assign y_data  = y_valid ? sat_val : '0;
    assign w_row   = row;
    assign w_col   = col;
    assign x_idx   = col;

endmodule

// File: tb/tb_rnn_matvec_mac.sv
`timescale 1ns/1ps
module tb_rnn_matvec_mac;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int AW    = 8;
    localparam int TOTAL = ROWS*(COLS+1) + 1;   // done cycle

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, y_valid;
    logic [AW-1:0] w_row, w_col, x_idx, y_idx;
    logic [DW-1:0] w_data, x_data, y_data;

    int Wm [ROWS][COLS];
    int xm [COLS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rnn_matvec_mac #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .FRAC(FRAC), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .x_idx(x_idx), .x_data(x_data),
        .y_valid(y_valid), .y_idx(y_idx), .y_data(y_data)
    );

    // Storage model: combinational read, same cycle.
    always_comb begin
        w_data = '0;
        x_data = '0;
        if (int'(w_row) < ROWS && int'(w_col) < COLS)
            w_data = DW'(Wm[int'(w_row)][int'(w_col)]);
        if (int'(x_idx) < COLS)
            x_data = DW'(xm[int'(x_idx)]);
    end

    // Reference: exact dot product, floor-divide by 2^FRAC, clamp to DW bits.
    function automatic int ref_row(int r);
        longint s = 0;
        longint q;
        longint lo = -(longint'(1) << (DW-1));
        longint hi = (longint'(1) << (DW-1)) - 1;
        longint d  = longint'(1) << FRAC;
        for (int c = 0; c < COLS; c++)
            s += longint'(Wm[r][c]) * longint'(xm[c]);
        if (s >= 0) q = s / d;
        else        q = -((-s + d - 1) / d);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    function automatic int rnd_val(bit full);
        if (full) return int'($urandom_range(65535)) - 32768;
        return int'($urandom_range(2047)) - 1024;
    endfunction

    task automatic clear_mem();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                Wm[r][c] = 0;
        for (int c = 0; c < COLS; c++) xm[c] = 0;
    endtask

    task automatic load_identity();
        clear_mem();
        for (int r = 0; r < ROWS; r++) Wm[r][r] = 256;
        xm[0] = 256; xm[1] = 512; xm[2] = -256; xm[3] = 0;
    endtask

    // One full run from a start pulse; checks every cycle's outputs.
    // glitch != 0 pulses start during that cycle of the run.
    task automatic run_check(string name, int glitch);
        int ey [ROWS];
        int ph, r;
        bit is_emit, is_mac;
        for (int i = 0; i < ROWS; i++) ey[i] = ref_row(i);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= TOTAL + 3; c++) begin
            @(negedge clk);
            start   = (glitch != 0 && c == glitch);
            ph      = (c-1) % (COLS+1);
            r       = (c-1) / (COLS+1);
            is_emit = (c <= ROWS*(COLS+1)) && ph == COLS;
            is_mac  = (c <= ROWS*(COLS+1)) && ph < COLS;
            checks++;
            if (y_valid !== is_emit) begin
                errors++;
                $display("FAIL %s c%0d y_valid: got %0b want %0b", name, c, y_valid, is_emit);
            end
            checks++;
            if (busy !== (c <= TOTAL)) begin
                errors++;
                $display("FAIL %s c%0d busy: got %0b want %0b", name, c, busy, c <= TOTAL);
            end
            checks++;
            if (done !== (c == TOTAL)) begin
                errors++;
                $display("FAIL %s c%0d done: got %0b want %0b", name, c, done, c == TOTAL);
            end
            if (is_emit) begin
                checks++;
                if (int'(y_idx) !== r) begin
                    errors++;
                    $display("FAIL %s c%0d y_idx: got %0d want %0d", name, c, y_idx, r);
                end
                checks++;
                if (int'($signed(y_data)) !== ey[r]) begin
                    errors++;
                    $display("FAIL %s row%0d y_data: got %0d want %0d", name, r, $signed(y_data), ey[r]);
                end
            end
            if (is_mac) begin
                checks++;
                if (int'(w_row) !== r || int'(w_col) !== ph || int'(x_idx) !== ph) begin
                    errors++;
                    $display("FAIL %s c%0d addr: got %0d/%0d/%0d want %0d/%0d/%0d",
                             name, c, w_row, w_col, x_idx, r, ph, ph);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, y_valid, y_idx, y_data, w_row, w_col, x_idx} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got busy%0b done%0b yv%0b yi%0d yd%0d wr%0d wc%0d xi%0d want all 0",
                     busy, done, y_valid, y_idx, y_data, w_row, w_col, x_idx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        load_identity();
        run_check("identity", 0);
    endtask

    task automatic test_saturation();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                Wm[r][c] = 32767;
        for (int c = 0; c < COLS; c++) xm[c] = 32767;
        run_check("sat_pos", 0);
        for (int c = 0; c < COLS; c++) Wm[1][c] = -32768;
        run_check("sat_neg", 0);
    endtask

    task automatic test_truncation();
        clear_mem();
        Wm[0][0] = 1;
        xm[0] = 128;  run_check("trunc_p128", 0);
        xm[0] = -128; run_check("trunc_m128", 0);
        xm[0] = -256; run_check("trunc_m256", 0);
    endtask

    task automatic test_mixed_signs();
        clear_mem();
        Wm[0][0] = 512; Wm[0][1] = -256; Wm[0][2] = 256; Wm[0][3] = 768;
        xm[0] = 256; xm[1] = 256; xm[2] = 512; xm[3] = -256;
        run_check("mixed", 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            bit full = n[0];
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    Wm[r][c] = rnd_val(full);
            for (int c = 0; c < COLS; c++) xm[c] = rnd_val(full);
            run_check($sformatf("random%0d", n), 0);
        end
    endtask

    task automatic test_start_ignored();
        load_identity();
        run_check("start_mid_run", 8);
    endtask

    // start held high: runs repeat with period TOTAL+1 (one idle cycle).
    task automatic test_back_to_back();
        int p;
        bit ev, ed, eb;
        load_identity();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 2*(TOTAL+1); c++) begin
            @(negedge clk);
            p  = ((c-1) % (TOTAL+1)) + 1;
            ev = (p < TOTAL) && ((p % (COLS+1)) == 0);
            ed = (p == TOTAL);
            eb = (p != TOTAL+1);
            checks++;
            if (y_valid !== ev || done !== ed || busy !== eb) begin
                errors++;
                $display("FAIL back_to_back c%0d yv/done/busy: got %0b%0b%0b want %0b%0b%0b",
                         c, y_valid, done, busy, ev, ed, eb);
            end
            if (c == 27) begin
                checks++;
                if (y_valid !== 1'b1 || y_idx !== '0 || int'($signed(y_data)) !== 256) begin
                    errors++;
                    $display("FAIL back_to_back second run first y: got v%0b i%0d d%0d want v1 i0 d256",
                             y_valid, y_idx, $signed(y_data));
                end
            end
        end
        // Cycle 44 was idle with start high, so a third run is in flight.
        start = 1'b0;
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back drain: busy got %0b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        load_identity();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(negedge clk);     // now in cycle 12
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, y_valid, y_idx, y_data, w_row, w_col, x_idx} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run outputs: got busy%0b done%0b yv%0b yi%0d yd%0d wr%0d wc%0d xi%0d want all 0",
                     busy, done, y_valid, y_idx, y_data, w_row, w_col, x_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            checks++;
            if (y_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_run idle c%0d: got yv%0b busy%0b want 0 0", c, y_valid, busy);
            end
        end
        run_check("identity_after_reset", 0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_saturation();
        test_truncation();
        test_mixed_signs();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
